mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TO_CYCLES, 16, maximum cycles spent waiting for moc in one memory phase before a timeout trap.
REQ-002 Ports: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Ports: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: start  in  1  request strobe, sampled only in IDLE.
REQ-005 Ports: op3  in  6  SPARC memory op3 (LDSB 001001, LDSH 001010, LDUB 000001, LDUH 000010, LD 000000, STB 000101, STH 000110, ST 000100).
REQ-006 Ports: addr  in  32  byte address; wdata  in  32  store data, right-justified.
REQ-007 Ports: busy  out  1  high in every state except IDLE.
REQ-008 Ports: done  out  1  one-cycle completion pulse; rdata  out  32  extended load result.
REQ-009 Ports: trap  out  1  one-cycle trap pulse; trap_cause  out  2  01 misaligned, 10 timeout, 11 illegal op3.
REQ-010 Ports: mfa  out  1  memory function active; mem_rw  out  1  1 = read, 0 = write; mem_addr  out  32  {addr[31:2],2'b00}.
REQ-011 Ports: mem_wdata  out  32  word written to memory; mem_rdata  in  32  word read; moc  in  1  memory operation complete.

Function
REQ-012 Size/sign decode: byte = LDSB/LDUB/STB, half = LDSH/LDUH/STH, word = LD/ST; signed only for LDSB/LDSH.
REQ-013 States: IDLE, READ, MERGE, WRITE, DONE, TRAP.
REQ-014 IDLE: start=1 with illegal op3 -> TRAP, cause 11; no mfa.
REQ-015 IDLE: start=1 with half and addr[0]=1, or word and addr[1:0]!=00 -> TRAP, cause 01; no mfa.
REQ-016 IDLE: legal aligned load, STB or STH -> READ; ST -> WRITE; start=0 -> stay IDLE.
REQ-017 op3, addr and wdata latched on the accepting edge; start ignored while busy=1.
REQ-018 READ/WRITE: mfa=1, mem_rw=1/0 held stable until moc sampled 1; mem_rdata captured on that edge.
REQ-019 READ on moc: load -> DONE; STB/STH -> MERGE.
REQ-020 MERGE: one cycle; latched word with target lane replaced by wdata low byte/half; -> WRITE.
REQ-021 WRITE on moc -> DONE; mem_wdata = merged word (STB/STH) or wdata (ST).
REQ-022 Lanes big-endian: byte offset 0 = bits[31:24] ... offset 3 = [7:0]; half offset 0 = [31:16], 2 = [15:0].
REQ-023 Load result: selected lane right-justified; sign-extended if signed, else zero-extended.
REQ-024 DONE: done=1 one cycle; rdata updated for loads, unchanged for stores; -> IDLE.
REQ-025 TRAP: trap=1 one cycle -> IDLE; trap_cause held until next accepted start.
REQ-026 Watchdog cleared on entering READ or WRITE, counts each cycle with moc=0; at TO_CYCLES -> TRAP, cause 10, mfa=0 next cycle.
REQ-027 Latency with moc on first mfa cycle: done in cycle start+2 for loads and ST, start+4 for STB/STH.
REQ-028 mfa never high in IDLE, MERGE, DONE or TRAP; moc outside READ/WRITE ignored.

Reset
REQ-029 reset=1 at a clock edge -> IDLE; busy, done, trap, mfa = 0; mem_rw = 1; rdata, trap_cause, mem_wdata = 0.
REQ-030 reset overrides all transitions, including mid-READ/WRITE; in-flight access abandoned, no done/trap.

Verification
REQ-031 LDSB addr 0x101, mem_rdata 0x12F45678, moc immediate -> one read phase, rdata 0xFFFFFFF4, done cycle start+2.
REQ-032 LDUH addr 0x102, mem_rdata 0x1234ABCD -> rdata 0x0000ABCD, mem_addr 0x100.
REQ-033 STB addr 0x203, wdata 0x000000AA, memory word 0x11223344 -> read then write, mem_wdata 0x112233AA, done cycle start+4.
REQ-034 LDSH addr 0x101 -> trap one cycle, trap_cause 01, mfa never asserted, rdata unchanged.
REQ-035 LD addr 0x300, moc held 0 -> mfa high 16 cycles, then trap, cause 10, mfa 0.
REQ-036 ST with moc held 0, reset asserted in third WRITE cycle -> next cycle mfa=0, busy=0, no done/trap.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle for mem_access_ctrl.
// Request side:  start, op3, addr, wdata in; busy, done, rdata, trap and
//                trap_cause back to the requester.
// Memory side:   mfa, mem_rw, mem_addr and mem_wdata out to memory;
//                mem_rdata and moc back from memory.
// The controller is the slave. The master drives the request inputs and
// plays the memory (mem_rdata, moc).
interface mem_access_ctrl_if;
  logic        start;
  logic [5:0]  op3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        mfa;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        moc;

  modport master (
    output start, op3, addr, wdata, mem_rdata, moc,
    input  busy, done, rdata, trap, trap_cause, mfa, mem_rw, mem_addr, mem_wdata
  );

  modport slave (
    input  start, op3, addr, wdata, mem_rdata, moc,
    output busy, done, rdata, trap, trap_cause, mfa, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// SPARC-style load/store sequencer.
// Ports:
//   clk    - single clock; all state updates on its rising edge.
//   reset  - synchronous, active-high reset.
//   bus    - mem_access_ctrl_if.slave. It carries the request strobe, op3,
//            address and store data in; busy, done, rdata, trap and
//            trap_cause out; and the memory handshake
//            (mfa/mem_rw/mem_addr/mem_wdata out, mem_rdata/moc in).
// A byte or half store does a read-modify-write: it reads the word, merges
// the new lane and writes the word back. A word store writes the word
// directly. Lanes are big-endian. A watchdog aborts any memory phase that
// waits too long for moc.
module mem_access_ctrl #(
  parameter int TO_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_TRAP  = 3'd5;

  localparam int              WD_W    = $clog2(TO_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYCLES - 1);

  logic [2:0]      state_reg;
  logic [31:0]     addr_reg;
  logic [15:0]     wdata_lo_reg;
  logic            is_load_reg, is_byte_reg, is_half_reg, is_signed_reg;
  logic [31:0]     word_reg;
  logic [31:0]     rdata_reg;
  logic [31:0]     mem_wdata_reg;
  logic [1:0]      cause_reg;
  logic [WD_W-1:0] wd_reg;

  // Decode of the incoming op3, used only on the accepting edge.
  logic in_legal, in_load, in_byte, in_half, in_signed, in_misaligned;

  always_comb begin
    in_legal = 1'b1;
    in_load  = 1'b0;
    in_byte  = 1'b0;
    in_half  = 1'b0;
    case (bus.op3)
      6'b001001, 6'b000001: begin in_byte = 1'b1; in_load = 1'b1; end
      6'b001010, 6'b000010: begin in_half = 1'b1; in_load = 1'b1; end
      6'b000000:            in_load = 1'b1;
      6'b000101:            in_byte = 1'b1;
      6'b000110:            in_half = 1'b1;
      6'b000100:            in_legal = 1'b1;
      default:              in_legal = 1'b0;
    endcase
    // Within the legal loads, op3[3] marks the signed variants (LDSB/LDSH).
    in_signed     = in_load & bus.op3[3];
    in_misaligned = (in_half & bus.addr[0]) |
                    (~in_byte & ~in_half & (bus.addr[1:0] != 2'b00));
  end

  // Load result: pick the big-endian lane from the returned word and extend it.
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

  always_comb begin
    case (addr_reg[1:0])
      2'd0:    lane_b = bus.mem_rdata[31:24];
      2'd1:    lane_b = bus.mem_rdata[23:16];
      2'd2:    lane_b = bus.mem_rdata[15:8];
      default: lane_b = bus.mem_rdata[7:0];
    endcase
    lane_h = addr_reg[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
    if (is_byte_reg)
      load_val = {{24{is_signed_reg & lane_b[7]}}, lane_b};
    else if (is_half_reg)
      load_val = {{16{is_signed_reg & lane_h[15]}}, lane_h};
    else
      load_val = bus.mem_rdata;
  end

  // Store merge: replace the target lane(s) of the word read back.
  // Byte lane gi sits at bits [31-8*gi -: 8]. A half store at offset 0
  // covers lanes 0 and 1. A half store at offset 2 covers lanes 2 and 3.
  logic [31:0] merged;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       lane_hit;
    logic [7:0] lane_src;
    assign lane_hit = is_byte_reg ? (addr_reg[1:0] == 2'(gi))
                                  : (addr_reg[1] == 1'(gi / 2));
    if (gi % 2 == 0) begin : g_even
      assign lane_src = is_half_reg ? wdata_lo_reg[15:8] : wdata_lo_reg[7:0];
    end else begin : g_odd
      assign lane_src = wdata_lo_reg[7:0];
    end
    assign merged[31-8*gi -: 8] = lane_hit ? lane_src : word_reg[31-8*gi -: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      wdata_lo_reg  <= '0;
      is_load_reg   <= 1'b0;
      is_byte_reg   <= 1'b0;
      is_half_reg   <= 1'b0;
      is_signed_reg <= 1'b0;
      word_reg      <= '0;
      rdata_reg     <= '0;
      mem_wdata_reg <= '0;
      cause_reg     <= 2'b00;
      wd_reg        <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            addr_reg      <= bus.addr;
            wdata_lo_reg  <= bus.wdata[15:0];
            is_load_reg   <= in_load;
            is_byte_reg   <= in_byte;
            is_half_reg   <= in_half;
            is_signed_reg <= in_signed;
            wd_reg        <= '0;
            if (!in_legal) begin
              cause_reg <= 2'b11;
              state_reg <= S_TRAP;
            end else if (in_misaligned) begin
              cause_reg <= 2'b01;
              state_reg <= S_TRAP;
            end else begin
              cause_reg <= 2'b00;
              if (in_load || in_byte || in_half) begin
                state_reg <= S_READ;
              end else begin
                mem_wdata_reg <= bus.wdata;
                state_reg     <= S_WRITE;
              end
            end
          end
        end
        S_READ: begin
          if (bus.moc) begin
            if (is_load_reg) begin
              rdata_reg <= load_val;
              state_reg <= S_DONE;
            end else begin
              word_reg  <= bus.mem_rdata;
              state_reg <= S_MERGE;
            end
          end else if (wd_reg == WD_LAST) begin
            cause_reg <= 2'b10;
            state_reg <= S_TRAP;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end
        S_MERGE: begin
          mem_wdata_reg <= merged;
          wd_reg        <= '0;
          state_reg     <= S_WRITE;
        end
        S_WRITE: begin
          if (bus.moc) begin
            state_reg <= S_DONE;
          end else if (wd_reg == WD_LAST) begin
            cause_reg <= 2'b10;
            state_reg <= S_TRAP;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end
        default: state_reg <= S_IDLE;  // DONE, TRAP and unused codes
      endcase
    end
  end

  assign bus.busy       = (state_reg != S_IDLE);
  assign bus.done       = (state_reg == S_DONE);
  assign bus.trap       = (state_reg == S_TRAP);
  assign bus.mfa        = (state_reg == S_READ) || (state_reg == S_WRITE);
  assign bus.mem_rw     = (state_reg != S_WRITE);
  assign bus.mem_addr   = {addr_reg[31:2], 2'b00};
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.rdata      = rdata_reg;
  assign bus.trap_cause = cause_reg;

endmodule
